// File: rtl/branch_resolver_if.sv
// Bus bundle between the fetch/execute stages and the branch resolver.
// master: pipeline side driving predictions and resolutions; slave: the resolver.
interface branch_resolver_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             stall;
  logic             pred_valid;
  logic [31:0]      pred_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             res_valid;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic             update_valid;
  logic [31:0]      update_pc;
  logic             update_result;
  logic             queue_full;
  logic             queue_empty;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  logic [1:0]       err_sticky;

  modport master (
    output stall, pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_taken, res_target,
    input  flush, redirect_pc, update_valid, update_pc, update_result,
    input  queue_full, queue_empty, branch_count, mispredict_count, err_sticky
  );

  modport slave (
    input  stall, pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_taken, res_target,
    output flush, redirect_pc, update_valid, update_pc, update_result,
    output queue_full, queue_empty, branch_count, mispredict_count, err_sticky
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: in-order queue of in-flight predictions, checked against
// EX outcomes. Mispredicts raise a one-cycle flush with the corrected PC and
// discard all younger (wrong-path) entries.
module branch_resolver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  branch_resolver_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e           state_q;
  logic [31:0]      mem_pc     [DEPTH];
  logic             mem_taken  [DEPTH];
  logic [31:0]      mem_target [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             flush_q, update_valid_q, update_result_q;
  logic [31:0]      redirect_pc_q, update_pc_q;
  logic [CNT_W-1:0] branch_count_q, mispredict_count_q;
  logic [1:0]       err_q;

  logic        full, empty, push_req, pop_req, do_push, do_pop;
  logic        underflow, overflow, mispredict;
  logic [31:0] head_pc, head_target, correct_pc;
  logic        head_taken;

  // Decode this cycle's push/pop and the compare against the oldest entry.
  always_comb begin
    full        = (count_q == FULL_CNT);
    empty       = (count_q == '0);
    push_req    = bus.pred_valid && !bus.stall && (state_q == StRun);
    pop_req     = bus.res_valid && !bus.stall && (state_q == StRun);
    do_pop      = pop_req && !empty;
    underflow   = pop_req && empty;
    head_pc     = mem_pc[rd_ptr_q];
    head_taken  = mem_taken[rd_ptr_q];
    head_target = mem_target[rd_ptr_q];
    mispredict  = do_pop && ((head_taken != bus.res_taken) ||
                             (bus.res_taken && (head_target != bus.res_target)));
    correct_pc  = bus.res_taken ? bus.res_target : head_pc + 32'd4;
    // A push alongside a mispredict is wrong-path: silently dropped.
    do_push     = push_req && (!full || do_pop) && !mispredict;
    overflow    = push_req && full && !do_pop;
  end

  // FSM, queue storage, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= StRun;
      rd_ptr_q           <= '0;
      wr_ptr_q           <= '0;
      count_q            <= '0;
      flush_q            <= 1'b0;
      redirect_pc_q      <= '0;
      update_valid_q     <= 1'b0;
      update_pc_q        <= '0;
      update_result_q    <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      err_q              <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_pc[i]     <= '0;
        mem_taken[i]  <= 1'b0;
        mem_target[i] <= '0;
      end
    end else begin
      // Pulses last exactly one cycle regardless of stall.
      flush_q        <= 1'b0;
      update_valid_q <= 1'b0;

      unique case (state_q)
        StRun:   if (mispredict) state_q <= StFlush;
        StFlush: state_q <= StRun;
        default: state_q <= StRun;
      endcase

      if (underflow) err_q[0] <= 1'b1;
      if (overflow)  err_q[1] <= 1'b1;

      if (do_pop) begin
        update_valid_q  <= 1'b1;
        update_pc_q     <= head_pc;
        update_result_q <= bus.res_taken;
        if (branch_count_q != '1) branch_count_q <= branch_count_q + 1'b1;
      end

      if (mispredict) begin
        flush_q       <= 1'b1;
        redirect_pc_q <= correct_pc;
        if (mispredict_count_q != '1) mispredict_count_q <= mispredict_count_q + 1'b1;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) begin
          mem_pc[wr_ptr_q]     <= bus.pred_pc;
          mem_taken[wr_ptr_q]  <= bus.pred_taken;
          mem_target[wr_ptr_q] <= bus.pred_target;
          wr_ptr_q             <= wr_ptr_q + PTR_ONE;
        end
        if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
        else if (!do_push && do_pop) count_q <= count_q - CNT_ONE;
      end
    end
  end

  assign bus.flush            = flush_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.update_valid     = update_valid_q;
  assign bus.update_pc        = update_pc_q;
  assign bus.update_result    = update_result_q;
  assign bus.queue_full       = full;
  assign bus.queue_empty      = empty;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;
  assign bus.err_sticky       = err_q;
endmodule
